avmm_burst_slave: RTL and testbench

AVMM_BURST_SLAVE -- requirements
Module: avmm_burst_slave

---
 rtl/avmm_burst_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_avmm_burst_slave.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_burst_slave.sv
// avmm_burst_slave: Avalon-MM burst slave over NREGS 32-bit registers.
// Reads stream one beat per cycle while waitrequest is held high; writes take
// one beat per cycle with write=1 and stall on idle cycles.
// Optional feature macro: AVMM_SLV_WRITERESP_EN adds a one-cycle write response.
// Handshake: a command is taken in IDLE on any rising edge where read or write
// is 1 (write wins over read). waitrequest=1 only in RD_BURST, and commands
// presented then are ignored. Read beats are signalled by readdatavalid and
// write completions by writeresponsevalid. Both are registered and never
// high in the same cycle.
module avmm_burst_slave #(
    parameter int NREGS     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [15:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    input  logic [10:0]           burstcount,
    input  logic                  beginbursttransfer,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    output logic [1:0]            response,
    output logic                  waitrequest,
    output logic                  writeresponsevalid,
    output logic [NREGS*32-1:0]   reg_q,
    output logic [1:0]            state_dbg_o
);

    localparam int          AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [16:0] NREGS_W = 17'(NREGS);
    localparam logic [10:0] MAX_BC  = 11'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] rd_ptr_q, rd_ptr_d;
    logic [10:0] rd_left_q, rd_left_d;
    logic [16:0] wr_ptr_q, wr_ptr_d;
    logic [10:0] wr_left_q, wr_left_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdv_q, rdv_d;
    logic [1:0]  resp_q, resp_d;
    logic        wrv_q, wrv_d;
    logic [31:0] regs_q [NREGS];

`ifdef AVMM_SLV_WRITERESP_EN
    logic        wr_err_q, wr_err_d;
`endif

    // Beat selection produced by the FSM, consumed by the data path below.
    logic        rd_beat;
    logic [16:0] rd_sel;
    logic        wr_beat;
    logic [16:0] wr_sel;
    logic        wr_en;
    logic [AW-1:0] wr_idx;

    // Address is widened by one bit so that start+i never wraps into range.
    logic [16:0] cmd_addr;
    logic        cmd_legal;
    logic        cmd_oor;
    logic        burst_oor;
    logic        unused_bbt;

    assign cmd_addr   = {1'b0, address};
    assign cmd_legal  = (burstcount != 11'd0) && (burstcount <= MAX_BC);
    assign cmd_oor    = (cmd_addr >= NREGS_W);
    assign burst_oor  = (wr_ptr_q >= NREGS_W);
    assign unused_bbt = beginbursttransfer;

    // State and pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            rd_left_q <= '0;
            wr_ptr_q  <= '0;
            wr_left_q <= '0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            resp_q    <= 2'b00;
            wrv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_left_q <= rd_left_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_left_q <= wr_left_d;
            rdata_q   <= rdata_d;
            rdv_q     <= rdv_d;
            resp_q    <= resp_d;
            wrv_q     <= wrv_d;
        end
    end

`ifdef AVMM_SLV_WRITERESP_EN
    // Sticky out-of-range flag for the write burst in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wr_err_q <= 1'b0;
        else          wr_err_q <= wr_err_d;
    end
`endif

    // Next-state logic, beat selection and registered-output next values.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_left_d = rd_left_q;
        wr_ptr_d  = wr_ptr_q;
        wr_left_d = wr_left_q;
        rdata_d   = 32'd0;
        rdv_d     = 1'b0;
        resp_d    = 2'b00;
        wrv_d     = 1'b0;
        rd_beat   = 1'b0;
        rd_sel    = rd_ptr_q;
        wr_beat   = 1'b0;
        wr_sel    = wr_ptr_q;
`ifdef AVMM_SLV_WRITERESP_EN
        wr_err_d  = wr_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (write) begin
                    if (cmd_legal) begin
                        wr_beat = 1'b1;
                        wr_sel  = cmd_addr;
                        if (burstcount > 11'd1) begin
                            state_d   = WR_BURST;
                            wr_ptr_d  = cmd_addr + 17'd1;
                            wr_left_d = burstcount - 11'd1;
`ifdef AVMM_SLV_WRITERESP_EN
                            wr_err_d  = cmd_oor;
`endif
                        end else begin
`ifdef AVMM_SLV_WRITERESP_EN
                            wrv_d  = 1'b1;
                            resp_d = cmd_oor ? 2'b11 : 2'b00;
`endif
                        end
                    end else begin
`ifdef AVMM_SLV_WRITERESP_EN
                        wrv_d  = 1'b1;
                        resp_d = 2'b10;
`endif
                    end
                end else if (read) begin
                    state_d = RD_BURST;
                    if (cmd_legal) begin
                        rd_beat   = 1'b1;
                        rd_sel    = cmd_addr;
                        rd_ptr_d  = cmd_addr + 17'd1;
                        rd_left_d = burstcount - 11'd1;
                    end else begin
                        // Illegal count: one error beat, then back to IDLE.
                        rdv_d     = 1'b1;
                        resp_d    = 2'b10;
                        rd_left_d = 11'd0;
                    end
                end
            end
            RD_BURST: begin
                if (rd_left_q == 11'd0) begin
                    state_d = IDLE;
                end else begin
                    rd_beat   = 1'b1;
                    rd_sel    = rd_ptr_q;
                    rd_ptr_d  = rd_ptr_q + 17'd1;
                    rd_left_d = rd_left_q - 11'd1;
                end
            end
            WR_BURST: begin
                if (write) begin
                    wr_beat   = 1'b1;
                    wr_sel    = wr_ptr_q;
                    wr_ptr_d  = wr_ptr_q + 17'd1;
                    wr_left_d = wr_left_q - 11'd1;
`ifdef AVMM_SLV_WRITERESP_EN
                    wr_err_d  = wr_err_q | burst_oor;
`endif
                    if (wr_left_q == 11'd1) begin
                        state_d = IDLE;
`ifdef AVMM_SLV_WRITERESP_EN
                        wrv_d  = 1'b1;
                        resp_d = (wr_err_q | burst_oor) ? 2'b11 : 2'b00;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_beat) begin
            rdv_d = 1'b1;
            if (rd_sel < NREGS_W) begin
                rdata_d = regs_q[rd_sel[AW-1:0]];
                resp_d  = 2'b00;
            end else begin
                rdata_d = 32'd0;
                resp_d  = 2'b11;
            end
        end
    end

    assign wr_en  = wr_beat && (wr_sel < NREGS_W);
    assign wr_idx = wr_sel[AW-1:0];

    // Register file with per-byte enables; out-of-range beats never reach it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) regs_q[wr_idx][8*k +: 8] <= writedata[8*k +: 8];
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regout
        assign reg_q[32*g +: 32] = regs_q[g];
    end

    assign readdata           = rdata_q;
    assign readdatavalid      = rdv_q;
    assign response           = resp_q;
    assign waitrequest        = (state_q == RD_BURST);
    assign writeresponsevalid = wrv_q;
    assign state_dbg_o        = state_q;

`ifndef AVMM_SLV_WRITERESP_EN
    logic unused_wr;
    assign unused_wr = burst_oor;
`endif

endmodule

// File: tb/tb_avmm_burst_slave.sv
// tb_avmm_burst_slave: directed bench for avmm_burst_slave (NREGS=16, MAX_BURST=16).
module tb_avmm_burst_slave;

    localparam int NREGS = 16;
`ifdef AVMM_SLV_WRITERESP_EN
    localparam logic WRESP = 1'b1;
`else
    localparam logic WRESP = 1'b0;
`endif

    logic               clock;
    logic               reset_n;
    logic [15:0]        address;
    logic               read;
    logic               write;
    logic [31:0]        writedata;
    logic [3:0]         byteenable;
    logic [10:0]        burstcount;
    logic               beginbursttransfer;
    logic [31:0]        readdata;
    logic               readdatavalid;
    logic [1:0]         response;
    logic               waitrequest;
    logic               writeresponsevalid;
    logic [NREGS*32-1:0] reg_q;
    logic [1:0]         state_dbg_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [NREGS];

    avmm_burst_slave #(.NREGS(NREGS), .MAX_BURST(16)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
        .readdata(readdata), .readdatavalid(readdatavalid), .response(response),
        .waitrequest(waitrequest), .writeresponsevalid(writeresponsevalid),
        .reg_q(reg_q), .state_dbg_o(state_dbg_o)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver tasks.
    task automatic drive_idle();
        read = 1'b0; write = 1'b0; address = 16'h0; writedata = 32'h0;
        byteenable = 4'h0; burstcount = 11'd0; beginbursttransfer = 1'b0;
    endtask

    task automatic drive_write(input logic [15:0] a, input logic [10:0] bc,
                               input logic [31:0] d, input logic [3:0] be);
        read = 1'b0; write = 1'b1; address = a; burstcount = bc;
        writedata = d; byteenable = be; beginbursttransfer = 1'b1;
    endtask

    task automatic drive_read(input logic [15:0] a, input logic [10:0] bc);
        read = 1'b1; write = 1'b0; address = a; burstcount = bc;
        writedata = 32'h0; byteenable = 4'h0; beginbursttransfer = 1'b1;
    endtask

    function automatic logic [NREGS*32-1:0] pack_exp();
        logic [NREGS*32-1:0] v;
        for (int i = 0; i < NREGS; i++) v[32*i +: 32] = exp_regs[i];
        return v;
    endfunction

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
        tick(); tick();
        if ({readdata, readdatavalid, response, waitrequest, writeresponsevalid} !== 36'h0) begin
            errors++; $display("FAIL reset_outputs: got rd=%h rdv=%b resp=%b wr=%b wrv=%b want all 0",
                               readdata, readdatavalid, response, waitrequest, writeresponsevalid);
        end
        checks++;
        if (reg_q !== '0 || state_dbg_o !== 2'd0) begin
            errors++; $display("FAIL reset_regs: got state=%0d regs=%h want 0", state_dbg_o, reg_q);
        end
        checks++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write_read();
        drive_write(16'd3, 11'd1, 32'hDEADBEEF, 4'hF);
        tick();
        drive_idle();
        exp_regs[3] = 32'hDEADBEEF;
        if (reg_q[32*3 +: 32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr3_reg: got %h want deadbeef", reg_q[32*3 +: 32]);
        end
        checks++;
        if (writeresponsevalid !== WRESP || response !== 2'b00 || readdatavalid !== 1'b0) begin
            errors++; $display("FAIL wr3_resp: got wrv=%b resp=%b rdv=%b want wrv=%b resp=00 rdv=0",
                               writeresponsevalid, response, readdatavalid, WRESP);
        end
        checks++;
        tick();
        drive_read(16'd3, 11'd1);
        tick();
        drive_idle();
        if (readdatavalid !== 1'b1 || readdata !== 32'hDEADBEEF || response !== 2'b00 || waitrequest !== 1'b1) begin
            errors++; $display("FAIL rd3_beat: got rdv=%b data=%h resp=%b wr=%b want 1 deadbeef 00 1",
                               readdatavalid, readdata, response, waitrequest);
        end
        checks++;
        tick();
        if (readdatavalid !== 1'b0 || readdata !== 32'h0 || waitrequest !== 1'b0 || state_dbg_o !== 2'd0) begin
            errors++; $display("FAIL rd3_after: got rdv=%b data=%h wr=%b state=%0d want 0 0 0 0",
                               readdatavalid, readdata, waitrequest, state_dbg_o);
        end
        checks++;
    endtask

    task automatic test_byteenable();
        drive_write(16'd5, 11'd1, 32'h11223344, 4'b0101);
        tick();
        drive_idle();
        exp_regs[5] = 32'h00220044;
        if (reg_q[32*5 +: 32] !== 32'h00220044) begin
            errors++; $display("FAIL be_reg5: got %h want 00220044", reg_q[32*5 +: 32]);
        end
        checks++;
        tick();
    endtask

    task automatic test_read_oob();
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        drive_write(16'd14, 11'd1, 32'hAAAA0014, 4'hF);
        tick();
        drive_write(16'd15, 11'd1, 32'hBBBB0015, 4'hF);
        tick();
        drive_idle();
        exp_regs[14] = 32'hAAAA0014;
        exp_regs[15] = 32'hBBBB0015;
        tick();
        exp_d[0] = 32'hAAAA0014; exp_d[1] = 32'hBBBB0015; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
        exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b11; exp_r[3] = 2'b11;
        drive_read(16'd14, 11'd4);
        tick();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            if (readdatavalid !== 1'b1 || waitrequest !== 1'b1 || readdata !== exp_d[i] || response !== exp_r[i]) begin
                errors++; $display("FAIL oob_beat%0d: got rdv=%b wr=%b data=%h resp=%b want 1 1 %h %b",
                                   i, readdatavalid, waitrequest, readdata, response, exp_d[i], exp_r[i]);
            end
            checks++;
            tick();
        end
        if (readdatavalid !== 1'b0 || waitrequest !== 1'b0 || response !== 2'b00) begin
            errors++; $display("FAIL oob_end: got rdv=%b wr=%b resp=%b want 0 0 00",
                               readdatavalid, waitrequest, response);
        end
        checks++;
    endtask

    task automatic test_write_burst_gap();
        drive_write(16'd0, 11'd3, 32'hA0A00000, 4'hF);
        tick();
        exp_regs[0] = 32'hA0A00000;
        if (state_dbg_o !== 2'd2 || waitrequest !== 1'b0 || reg_q[31:0] !== 32'hA0A00000) begin
            errors++; $display("FAIL wb_beat0: got state=%0d wr=%b reg0=%h want 2 0 a0a00000",
                               state_dbg_o, waitrequest, reg_q[31:0]);
        end
        checks++;
        drive_write(16'd9, 11'd0, 32'hA1A10001, 4'hF);
        tick();
        exp_regs[1] = 32'hA1A10001;
        drive_idle();
        writedata = 32'hFFFFFFFF;
        byteenable = 4'hF;
        tick();
        if (state_dbg_o !== 2'd2 || reg_q[32*1 +: 32] !== 32'hA1A10001 || reg_q[32*2 +: 32] !== 32'h0) begin
            errors++; $display("FAIL wb_gap: got state=%0d reg1=%h reg2=%h want 2 a1a10001 0",
                               state_dbg_o, reg_q[32*1 +: 32], reg_q[32*2 +: 32]);
        end
        checks++;
        drive_write(16'd7, 11'd5, 32'hA2A20002, 4'hF);
        tick();
        drive_idle();
        exp_regs[2] = 32'hA2A20002;
        if (reg_q !== pack_exp()) begin
            errors++; $display("FAIL wb_regs: got reg0..2=%h %h %h want a0a00000 a1a10001 a2a20002",
                               reg_q[31:0], reg_q[63:32], reg_q[95:64]);
        end
        checks++;
        if (writeresponsevalid !== WRESP || response !== 2'b00 || state_dbg_o !== 2'd0) begin
            errors++; $display("FAIL wb_resp: got wrv=%b resp=%b state=%0d want %b 00 0",
                               writeresponsevalid, response, state_dbg_o, WRESP);
        end
        checks++;
        tick();
        if (writeresponsevalid !== 1'b0) begin
            errors++; $display("FAIL wb_resp_pulse: got wrv=%b want 0", writeresponsevalid);
        end
        checks++;
    endtask

    task automatic test_illegal();
        logic [10:0] bcs [2];
        bcs[0] = 11'd0; bcs[1] = 11'd17;
        for (int i = 0; i < 2; i++) begin
            drive_read(16'd3, bcs[i]);
            tick();
            drive_idle();
            if (readdatavalid !== 1'b1 || readdata !== 32'h0 || response !== 2'b10) begin
                errors++; $display("FAIL ill_rd_bc%0d: got rdv=%b data=%h resp=%b want 1 0 10",
                                   bcs[i], readdatavalid, readdata, response);
            end
            checks++;
            tick();
            if (readdatavalid !== 1'b0 || state_dbg_o !== 2'd0) begin
                errors++; $display("FAIL ill_rd_single%0d: got rdv=%b state=%0d want 0 0",
                                   bcs[i], readdatavalid, state_dbg_o);
            end
            checks++;
        end
        drive_write(16'd1, 11'd0, 32'hFFFFFFFF, 4'hF);
        tick();
        drive_idle();
        if (reg_q !== pack_exp() || writeresponsevalid !== WRESP ||
            response !== (WRESP ? 2'b10 : 2'b00) || state_dbg_o !== 2'd0) begin
            errors++; $display("FAIL ill_wr: got reg1=%h wrv=%b resp=%b state=%0d want a1a10001 %b %b 0",
                               reg_q[63:32], writeresponsevalid, response, state_dbg_o,
                               WRESP, (WRESP ? 2'b10 : 2'b00));
        end
        checks++;
        tick();
    endtask

    task automatic test_oor_write();
        drive_write(16'd20, 11'd1, 32'h12345678, 4'hF);
        tick();
        drive_idle();
        if (reg_q !== pack_exp() || writeresponsevalid !== WRESP ||
            response !== (WRESP ? 2'b11 : 2'b00)) begin
            errors++; $display("FAIL oor_wr: got wrv=%b resp=%b regs_ok=%b want %b %b 1",
                               writeresponsevalid, response, (reg_q === pack_exp()),
                               WRESP, (WRESP ? 2'b11 : 2'b00));
        end
        checks++;
        tick();
    endtask

    task automatic test_back_to_back();
        drive_write(16'd2, 11'd1, 32'h0B0B0B0B, 4'hF);
        tick();
        exp_regs[2] = 32'h0B0B0B0B;
        drive_read(16'd2, 11'd1);
        if (writeresponsevalid !== WRESP || readdatavalid !== 1'b0) begin
            errors++; $display("FAIL b2b_resp: got wrv=%b rdv=%b want %b 0",
                               writeresponsevalid, readdatavalid, WRESP);
        end
        checks++;
        tick();
        drive_idle();
        if (readdatavalid !== 1'b1 || readdata !== 32'h0B0B0B0B || writeresponsevalid !== 1'b0) begin
            errors++; $display("FAIL b2b_read: got rdv=%b data=%h wrv=%b want 1 0b0b0b0b 0",
                               readdatavalid, readdata, writeresponsevalid);
        end
        checks++;
        tick();
    endtask

    task automatic test_max_burst();
        int beats = 0;
        drive_read(16'd0, 11'd16);
        tick();
        drive_idle();
        for (int i = 0; i < 20; i++) begin
            if (readdatavalid === 1'b1) beats++;
            tick();
        end
        if (beats != 16 || state_dbg_o !== 2'd0) begin
            errors++; $display("FAIL max_burst: got beats=%0d state=%0d want 16 0", beats, state_dbg_o);
        end
        checks++;
    endtask

    task automatic test_reset_mid_burst();
        drive_read(16'd0, 11'd8);
        tick();
        drive_idle();
        tick();
        tick();
        if (readdatavalid !== 1'b1 || readdata !== exp_regs[2]) begin
            errors++; $display("FAIL rst_beat2: got rdv=%b data=%h want 1 %h",
                               readdatavalid, readdata, exp_regs[2]);
        end
        checks++;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
        if ({readdata, readdatavalid, response, waitrequest, writeresponsevalid} !== 36'h0 ||
            state_dbg_o !== 2'd0 || reg_q !== '0) begin
            errors++; $display("FAIL rst_mid: got rd=%h rdv=%b resp=%b wr=%b state=%0d regs_zero=%b want 0",
                               readdata, readdatavalid, response, waitrequest, state_dbg_o, (reg_q === '0));
        end
        checks++;
        tick();
        reset_n = 1'b1;
        drive_read(16'd31, 11'd1);
        tick();
        drive_idle();
        if (readdatavalid !== 1'b1 || response !== 2'b11 || waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_first_cmd: got rdv=%b resp=%b wr=%b want 1 11 1",
                               readdatavalid, response, waitrequest);
        end
        checks++;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        drive_idle();
        test_reset();
        test_single_write_read();
        test_byteenable();
        test_read_oob();
        test_write_burst_gap();
        test_illegal();
        test_oor_write();
        test_back_to_back();
        test_max_burst();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
